ext_pipe_unit: RTL

- Parametrised, handshaked immediate-extension unit. Successor to the combinational 16->32 zero/sign extender.
- Accepts an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit extended result.
- The result is registered into a 2-entry output queue with a valid/ready handshake, so the unit can sit between decode and execute in the pipelined CPU.
- Adds LUI-style high placement and branch-offset (sign-extend, shift-left-2) modes, plus a flush for branch mispredicts.

---
 rtl/ext_pipe_unit.sv | 79 +++++++
 1 files changed

// File: rtl/ext_pipe_unit.sv
// Immediate extender (zero/sign/high-place/branch-offset) feeding a 2-entry valid/ready output queue.
// One-cycle latency into an empty queue; in_ready drops while both entries are held.
module ext_pipe_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       count
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_res;
    logic [OUT_W-1:0] entry [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             push;
    logic             pop;

    assign zext = {{PAD_W{1'b0}}, in_data};
    assign sext = {{PAD_W{in_data[IN_W-1]}}, in_data};

    always_comb begin
        ext_res = zext;
        case (in_mode)
            2'b00:   ext_res = zext;
            2'b01:   ext_res = sext;
            2'b10:   ext_res = zext << PAD_W;
            2'b11:   ext_res = sext << 2;
            default: ext_res = zext;
        endcase
    end

    // Handshake outputs depend on occupancy only, so no comb path from in_valid/out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = out_valid ? entry[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= ext_res;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
